// File: rtl/alu_result_buffer.sv
// alu_result_buffer: FWFT result FIFO behind the serial ALU.
// It re-presents single-cycle result pulses as a valid/ready stream.
// It issues credit so that results are not dropped under backpressure.
// It also keeps a sticky overflow flag and a wrapping accepted-result count for debug.
module alu_result_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         issue_vld,
  input  logic                         issue_rdy,
  input  logic [7:0]                   res_dat,
  input  logic                         res_vld,
  output logic                         credit,
  output logic [7:0]                   out_dat,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  output logic [CNT_W-1:0]             result_count
);

  localparam int unsigned DAT_W = 8;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = LVL_W + 1;

  logic [DAT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [LVL_W-1:0] inflight;
  logic [LVL_W-1:0] inflight_nxt;
  logic [LVL_W-1:0] level_nxt;
  logic             issue_fire_c;
  logic             pop_c;
  logic             full_c;
  logic             wr_ok_c;
  logic             drop_c;

  // Handshake decode; a full FIFO still takes a write when the head leaves in the same cycle
  always_comb begin
    issue_fire_c = issue_vld && issue_rdy;
    pop_c        = out_vld && out_rdy;
    full_c       = (level == LVL_W'(DEPTH));
    wr_ok_c      = res_vld && (!full_c || pop_c);
    drop_c       = res_vld && full_c && !pop_c;
  end

  // Head presentation and credit, all derived from registered state only
  always_comb begin
    out_vld = (level != '0);
    out_dat = mem[rd_ptr];
    credit  = (SUM_W'(level) + SUM_W'(inflight)) < SUM_W'(DEPTH);
  end

  // Outstanding-issue tracker, saturating at both ends
  always_comb begin
    inflight_nxt = inflight;
    if (issue_fire_c && !res_vld && (inflight != LVL_W'(DEPTH))) begin
      inflight_nxt = inflight + LVL_W'(1);
    end else if (!issue_fire_c && res_vld && (inflight != '0)) begin
      inflight_nxt = inflight - LVL_W'(1);
    end
  end

  // Occupancy after this cycle's write and pop
  always_comb begin
    level_nxt = level;
    case ({wr_ok_c, pop_c})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  // Control state: pointers, occupancy, inflight, debug flags
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      level        <= '0;
      inflight     <= '0;
      overflow     <= 1'b0;
      result_count <= '0;
    end else begin
      level    <= level_nxt;
      inflight <= inflight_nxt;
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (wr_ok_c) begin
        wr_ptr       <= wr_ptr + PTR_W'(1);
        result_count <= result_count + CNT_W'(1);
      end
      if (drop_c) begin
        overflow <= 1'b1;
      end
    end
  end

  // Data storage; no reset needed since out_dat is only meaningful while out_vld
  always_ff @(posedge clock) begin
    if (!reset && wr_ok_c) begin
      mem[wr_ptr] <= res_dat;
    end
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Testbench for alu_result_buffer: a vector table plus directed multi-cycle sequences.
module tb_alu_result_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic             clock;
  logic             reset;
  logic             issue_vld;
  logic             issue_rdy;
  logic [7:0]       res_dat;
  logic             res_vld;
  logic             credit;
  logic [7:0]       out_dat;
  logic             out_vld;
  logic             out_rdy;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic [CNT_W-1:0] result_count;

  int n_checks = 0;
  int n_fail   = 0;

  alu_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .issue_vld(issue_vld), .issue_rdy(issue_rdy),
    .res_dat(res_dat), .res_vld(res_vld), .credit(credit), .out_dat(out_dat),
    .out_vld(out_vld), .out_rdy(out_rdy), .level(level), .overflow(overflow),
    .result_count(result_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic             rst;
    logic             iss;
    logic             rv;
    logic [7:0]       rd;
    logic             ordy;
    logic             e_vld;
    logic [7:0]       e_dat;
    logic [LVL_W-1:0] e_lvl;
    logic             e_cr;
    logic             e_ovf;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  localparam int NV = 17;
  vec_t vec [NV];

  function automatic vec_t mk(input logic rst, input logic iss, input logic rv,
                              input logic [7:0] rd, input logic ordy,
                              input logic e_vld, input logic [7:0] e_dat,
                              input int e_lvl, input logic e_cr, input logic e_ovf,
                              input int e_cnt);
    vec_t v;
    v.rst = rst; v.iss = iss; v.rv = rv; v.rd = rd; v.ordy = ordy;
    v.e_vld = e_vld; v.e_dat = e_dat; v.e_lvl = LVL_W'(e_lvl);
    v.e_cr = e_cr; v.e_ovf = e_ovf; v.e_cnt = CNT_W'(e_cnt);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge
  task automatic step(input logic rst, input logic iss, input logic rv,
                      input logic [7:0] rd, input logic ordy);
    reset = rst; issue_vld = iss; issue_rdy = iss; res_vld = rv; res_dat = rd; out_rdy = ordy;
    @(posedge clock);
    #1;
    reset = 1'b0; issue_vld = 1'b0; issue_rdy = 1'b0; res_vld = 1'b0; res_dat = 8'h00;
  endtask

  initial begin
    reset = 1'b1; issue_vld = 1'b0; issue_rdy = 1'b0; res_vld = 1'b0; res_dat = 8'h00; out_rdy = 1'b0;

    //          rst iss rv rd     ordy  vld dat    lvl cr ovf cnt
    vec[0]  = mk(1, 0, 0, 8'h00, 0,    0, 8'h00, 0, 1, 0, 0);
    vec[1]  = mk(0, 1, 0, 8'h00, 0,    0, 8'h00, 0, 1, 0, 0);
    vec[2]  = mk(0, 0, 1, 8'h01, 0,    1, 8'h01, 1, 1, 0, 1);
    vec[3]  = mk(0, 1, 0, 8'h00, 0,    1, 8'h01, 1, 1, 0, 1);
    vec[4]  = mk(0, 0, 1, 8'h02, 0,    1, 8'h01, 2, 1, 0, 2);
    vec[5]  = mk(0, 1, 0, 8'h00, 0,    1, 8'h01, 2, 1, 0, 2);
    vec[6]  = mk(0, 0, 1, 8'h03, 0,    1, 8'h01, 3, 1, 0, 3);
    vec[7]  = mk(0, 1, 0, 8'h00, 0,    1, 8'h01, 3, 0, 0, 3);
    vec[8]  = mk(0, 0, 1, 8'h04, 0,    1, 8'h01, 4, 0, 0, 4);
    vec[9]  = mk(0, 0, 1, 8'h77, 1,    1, 8'h02, 4, 0, 0, 5);
    vec[10] = mk(0, 0, 1, 8'hEE, 0,    1, 8'h02, 4, 0, 1, 5);
    vec[11] = mk(0, 0, 0, 8'h00, 0,    1, 8'h02, 4, 0, 1, 5);
    vec[12] = mk(0, 0, 0, 8'h00, 1,    1, 8'h03, 3, 1, 1, 5);
    vec[13] = mk(0, 0, 0, 8'h00, 1,    1, 8'h04, 2, 1, 1, 5);
    vec[14] = mk(0, 0, 0, 8'h00, 1,    1, 8'h77, 1, 1, 1, 5);
    vec[15] = mk(0, 0, 0, 8'h00, 1,    0, 8'h00, 0, 1, 1, 5);
    vec[16] = mk(1, 0, 0, 8'h00, 0,    0, 8'h00, 0, 1, 0, 0);

    for (int i = 0; i < NV; i++) begin
      step(vec[i].rst, vec[i].iss, vec[i].rv, vec[i].rd, vec[i].ordy);
      check($sformatf("vec%0d out_vld", i), 32'(out_vld), 32'(vec[i].e_vld));
      if (vec[i].e_vld) check($sformatf("vec%0d out_dat", i), 32'(out_dat), 32'(vec[i].e_dat));
      check($sformatf("vec%0d level", i), 32'(level), 32'(vec[i].e_lvl));
      check($sformatf("vec%0d credit", i), 32'(credit), 32'(vec[i].e_cr));
      check($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vec[i].e_ovf));
      check($sformatf("vec%0d count", i), 32'(result_count), 32'(vec[i].e_cnt));
    end

    // Single op: one-cycle latency, no bypass, one-cycle visibility with out_rdy high
    step(1, 0, 0, 8'h00, 1);
    step(0, 1, 0, 8'h00, 1);
    check("single credit after issue", 32'(credit), 32'd1);
    for (int c = 0; c < 8; c++) step(0, 0, 0, 8'h00, 1);
    reset = 1'b0; res_vld = 1'b1; res_dat = 8'h5A; out_rdy = 1'b1;
    #1;
    check("single no bypass", 32'(out_vld), 32'd0);
    @(posedge clock);
    #1;
    res_vld = 1'b0; res_dat = 8'h00;
    check("single out_vld", 32'(out_vld), 32'd1);
    check("single out_dat", 32'(out_dat), 32'h5A);
    check("single count", 32'(result_count), 32'd1);
    step(0, 0, 0, 8'h00, 1);
    check("single popped", 32'(out_vld), 32'd0);

    // Backpressure hold: head stays put while a second write lands
    step(0, 0, 1, 8'h33, 0);
    check("bp level1", 32'(level), 32'd1);
    for (int c = 0; c < 5; c++) begin
      step(0, 0, (c == 1), 8'h44, 0);
      check($sformatf("bp hold dat c%0d", c), 32'(out_dat), 32'h33);
      check($sformatf("bp level c%0d", c), 32'(level), (c >= 1) ? 32'd2 : 32'd1);
    end
    step(0, 0, 0, 8'h00, 1);
    check("bp second head", 32'(out_dat), 32'h44);

    // Reset mid-stream with level 3 and inflight 1
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 1, 8'hA1, 0);
    step(0, 0, 1, 8'hA2, 0);
    step(0, 0, 1, 8'hA3, 0);
    step(0, 1, 0, 8'h00, 0);
    check("mid level3", 32'(level), 32'd3);
    check("mid credit0", 32'(credit), 32'd0);
    step(1, 0, 0, 8'h00, 0);
    check("mid rst level", 32'(level), 32'd0);
    check("mid rst vld", 32'(out_vld), 32'd0);
    check("mid rst ovf", 32'(overflow), 32'd0);
    check("mid rst count", 32'(result_count), 32'd0);
    check("mid rst credit", 32'(credit), 32'd1);
    step(0, 0, 1, 8'h10, 0);
    check("mid post level", 32'(level), 32'd1);
    check("mid post dat", 32'(out_dat), 32'h10);
    check("mid post count", 32'(result_count), 32'd1);
    step(0, 1, 0, 8'h00, 0);
    step(0, 1, 0, 8'h00, 0);
    check("mid inflight2 credit", 32'(credit), 32'd1);
    step(0, 1, 0, 8'h00, 0);
    check("mid inflight3 credit", 32'(credit), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the serial ALU.
- Captures each single-cycle result pulse from the ALU into a small first-word-fall-through (FWFT) FIFO and re-presents the results as a valid/ready stream.
- Generates a credit signal that the issuing logic ANDs into its request valid, so results are never dropped under consumer backpressure.
- Also keeps a sticky overflow flag and a wrapping accepted-result counter for debug.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of result_count.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high; clock clock.
- issue_vld  input  1  ALU request valid (snooped).
- issue_rdy  input  1  ALU request ready (snooped); issue fires when issue_vld && issue_rdy.
- res_dat  input  8  ALU result data.
- res_vld  input  1  ALU result strobe; exactly one cycle per result; no backpressure possible.
- credit  output  1  high when one more issue is guaranteed buffer space.
- out_dat  output  8  head-of-FIFO data.
- out_vld  output  1  FIFO non-empty.
- out_rdy  input  1  consumer accept.
- level  output  $clog2(DEPTH+1)  entries currently stored.
- overflow  output  1  sticky: a result was dropped.
- result_count  output  CNT_W  number of results accepted, wrapping.

Behaviour:
Reset
- While reset is high at a clock edge: level=0, rd/wr pointers=0, inflight=0, overflow=0, result_count=0.
- All inputs are ignored in that cycle.
- After reset: out_vld=0, credit=1. out_dat is don't-care while out_vld=0.

Inflight counter
- Internal, width $clog2(DEPTH+1); counts issues not yet returned.
- +1 on issue fire, -1 on res_vld; both in the same cycle leaves it unchanged.
- Decrement saturates at 0: a stray res_vld with inflight==0 is still written.
- Increment saturates at DEPTH.

Credit
- credit = (level + inflight) < DEPTH.
- Combinational from registers only; no dependence on same-cycle inputs.

Pop
- Occurs when out_vld && out_rdy.
- Head advances at the clock edge.
- out_vld must not depend combinationally on out_rdy.

Write acceptance
- On res_vld, the write is accepted if level < DEPTH, or if level == DEPTH and a pop occurs in the same cycle.
- An accepted write stores res_dat at the tail and increments result_count, wrapping at 2^CNT_W.

Drop
- res_vld with level == DEPTH and no pop: data discarded, overflow <= 1.
- overflow stays set until reset; result_count is not incremented.

Latency
- A res_vld accepted in cycle N makes the entry visible on out_vld/out_dat in cycle N+1.
- No same-cycle bypass, including when the FIFO is empty.

Level update
- Next level = level + accepted_write - pop.
- Simultaneous write and pop leaves level unchanged.
- Pointers wrap modulo DEPTH.

Ordering
- Strict FIFO; out_dat equals the oldest accepted res_dat.
- out_dat is stable while out_vld && !out_rdy.

Reset mid-operation
- Stored and inflight results are discarded.
- A res_vld arriving after reset deasserts is accepted normally; inflight saturates at 0.

Test Plan:
- Single op: reset, issue fire at cycle 2, res_vld with res_dat=0x5A at cycle 11, out_rdy=1 -> out_vld=1 with out_dat=0x5A at cycle 12 only; result_count=1; credit low from cycle 3 only when level+inflight reaches DEPTH.
- Fill with DEPTH=4 and out_rdy=0: four issue/result pairs with data 0x01..0x04 -> level=4, credit=0 after the 4th issue, overflow=0. Then out_rdy=1 -> outputs 0x01,0x02,0x03,0x04 on consecutive cycles, then out_vld=0.
- Full plus simultaneous pop/write: level=4, out_rdy=1 and res_vld with 0x77 in the same cycle -> level stays 4, overflow=0, 0x77 emerges last.
- Forced overflow (ignoring credit): level=4, out_rdy=0, res_vld with 0xEE -> overflow=1 and stays set; level=4; result_count unchanged; 0xEE never appears on out_dat.
- Backpressure hold: out_vld=1, out_dat=0x33, out_rdy=0 for 5 cycles while a write lands -> out_dat holds 0x33, level goes from 1 to 2.
- Reset mid-stream: level=3, inflight=1, reset for 1 cycle -> level=0, out_vld=0, overflow=0, result_count=0, credit=1. A following res_vld with 0x10 is accepted and inflight remains 0.
